pipe_ctrl_unit: RTL and testbench

Parametrised pipelined control unit for the five-stage RV32I core. It combines the main opcode decoder with the ID/EX, EX/MEM and MEM/WB control-bundle registers. It also adds load-use hazard detection, branch flush, an external freeze, optional LUI/AUIPC support and sticky illegal-opcode capture. It sits in the ID stage and drives every stage's control inputs, so datapath stage registers carry data only.

---
 rtl/ctrl_pkg.sv | 64 ++++++
 rtl/ctrl_decode.sv | 90 +++++++++
 rtl/pipe_ctrl_unit.sv | 115 +++++++++++
 tb/tb_pipe_ctrl_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, selector enums and per-stage control bundles shared by the pipe control unit
package ctrl_pkg;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [1:0] ALU_BRANCH = 2'b01;
   localparam logic [1:0] ALU_FUNCT  = 2'b10;

   typedef enum logic [1:0] {A_RS1 = 2'b00, A_PC = 2'b01, A_ZERO = 2'b10} a_sel_e;
   typedef enum logic [1:0] {WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC4 = 2'b10} wb_sel_e;

   typedef struct packed {
      logic       alu_src;
      a_sel_e     a_sel;
      logic [1:0] alu_op;
      logic       branch;
      logic       jal;
      logic       jalr;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      wb_sel_e    wb_sel;
   } ctrl_bundle_t;

   // Later stages only carry the fields still consumed downstream.
   typedef struct packed {
      logic    mem_read;
      logic    mem_write;
      logic    reg_write;
      wb_sel_e wb_sel;
   } mem_bundle_t;

   typedef struct packed {
      logic    reg_write;
      wb_sel_e wb_sel;
   } wb_bundle_t;

   localparam ctrl_bundle_t CTRL_BUBBLE = '0;
   localparam mem_bundle_t  MEM_BUBBLE  = '0;
   localparam wb_bundle_t   WB_BUBBLE   = '0;

   function automatic mem_bundle_t to_mem(input ctrl_bundle_t c);
      mem_bundle_t m;
      m.mem_read  = c.mem_read;
      m.mem_write = c.mem_write;
      m.reg_write = c.reg_write;
      m.wb_sel    = c.wb_sel;
      return m;
   endfunction

   function automatic wb_bundle_t to_wb(input mem_bundle_t m);
      wb_bundle_t w;
      w.reg_write = m.reg_write;
      w.wb_sel    = m.wb_sel;
      return w;
   endfunction
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational RV32I main decoder
//   valid, opcode       in   instruction present in ID and its bits [6:0]
//   ctrl                out  control bundle; bubble when invalid or illegal
//   uses_rs1, uses_rs2  out  source registers actually read (for hazard checks)
//   is_illegal          out  valid instruction with an unsupported opcode
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter bit ENABLE_UPPER = 1'b1
) (
   input  logic         valid,
   input  logic [6:0]   opcode,
   output ctrl_bundle_t ctrl,
   output logic         uses_rs1,
   output logic         uses_rs2,
   output logic         is_illegal
);
   always_comb begin
      ctrl       = CTRL_BUBBLE;
      uses_rs1   = 1'b0;
      uses_rs2   = 1'b0;
      is_illegal = 1'b0;
      if (valid) begin
         case (opcode)
            OP_R: begin
               ctrl.alu_op    = ALU_FUNCT;
               ctrl.reg_write = 1'b1;
               uses_rs1       = 1'b1;
               uses_rs2       = 1'b1;
            end
            OP_I: begin
               ctrl.alu_src   = 1'b1;
               ctrl.alu_op    = ALU_FUNCT;
               ctrl.reg_write = 1'b1;
               uses_rs1       = 1'b1;
            end
            OP_LW: begin
               ctrl.alu_src   = 1'b1;
               ctrl.mem_read  = 1'b1;
               ctrl.reg_write = 1'b1;
               ctrl.wb_sel    = WB_MEM;
               uses_rs1       = 1'b1;
            end
            OP_SW: begin
               ctrl.alu_src   = 1'b1;
               ctrl.mem_write = 1'b1;
               uses_rs1       = 1'b1;
               uses_rs2       = 1'b1;
            end
            OP_BR: begin
               ctrl.branch = 1'b1;
               ctrl.alu_op = ALU_BRANCH;
               uses_rs1    = 1'b1;
               uses_rs2    = 1'b1;
            end
            OP_JAL: begin
               ctrl.jal       = 1'b1;
               ctrl.reg_write = 1'b1;
               ctrl.wb_sel    = WB_PC4;
            end
            OP_JALR: begin
               ctrl.jalr      = 1'b1;
               ctrl.alu_src   = 1'b1;
               ctrl.reg_write = 1'b1;
               ctrl.wb_sel    = WB_PC4;
               uses_rs1       = 1'b1;
            end
            OP_LUI: begin
               if (ENABLE_UPPER) begin
                  ctrl.alu_src   = 1'b1;
                  ctrl.a_sel     = A_ZERO;
                  ctrl.reg_write = 1'b1;
               end else begin
                  is_illegal = 1'b1;
               end
            end
            OP_AUIPC: begin
               if (ENABLE_UPPER) begin
                  ctrl.alu_src   = 1'b1;
                  ctrl.a_sel     = A_PC;
                  ctrl.reg_write = 1'b1;
               end else begin
                  is_illegal = 1'b1;
               end
            end
            default: is_illegal = 1'b1;
         endcase
      end
   end
endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: ID-stage control unit for the 5-stage RV32I core
//   clk, reset                 in   clock, synchronous active-high reset
//   id_valid, id_opcode        in   instruction in ID and its opcode
//   id_rs1, id_rs2, id_rd      in   register indices from ID
//   flush, hold                in   squash ID (taken branch), global freeze
//   stall                      out  load-use stall of PC and IF/ID
//   ex_*                       out  EX-stage control and destination
//   mem_read/mem_write/mem_rd  out  MEM-stage control and destination
//   wb_reg_write/wb_sel/wb_rd  out  WB-stage control and destination
//   illegal, illegal_opcode    out  sticky illegal flag and first offending opcode
module pipe_ctrl_unit
   import ctrl_pkg::*;
#(
   parameter int REG_ADDR_W    = 5,
   parameter bit ENABLE_UPPER  = 1'b1,
   parameter bit ENABLE_HAZARD = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [6:0]            id_opcode,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  flush,
   input  logic                  hold,
   output logic                  stall,
   output logic                  ex_alu_src,
   output logic [1:0]            ex_a_sel,
   output logic [1:0]            ex_alu_op,
   output logic                  ex_branch,
   output logic                  ex_jalr,
   output logic                  ex_jal,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [REG_ADDR_W-1:0] mem_rd,
   output logic                  wb_reg_write,
   output logic [1:0]            wb_sel,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic                  illegal,
   output logic [6:0]            illegal_opcode
);
   ctrl_bundle_t          dec_ctrl, ex_d, ex_q;
   mem_bundle_t           mem_d, mem_q;
   wb_bundle_t            wb_d, wb_q;
   logic [REG_ADDR_W-1:0] dec_rd, ex_rd_d, ex_rd_q, mem_rd_d, mem_rd_q, wb_rd_d, wb_rd_q;
   logic                  uses_rs1, uses_rs2, is_illegal, rs_match, kill_id;
   logic                  ill_d, ill_q;
   logic [6:0]            ill_op_d, ill_op_q;

   ctrl_decode #(.ENABLE_UPPER(ENABLE_UPPER)) u_decode (
      .valid      (id_valid),
      .opcode     (id_opcode),
      .ctrl       (dec_ctrl),
      .uses_rs1   (uses_rs1),
      .uses_rs2   (uses_rs2),
      .is_illegal (is_illegal)
   );

   always_comb begin
      // Only writing instructions keep rd, so SW/BR/bubbles all carry rd=0.
      dec_rd   = dec_ctrl.reg_write ? id_rd : '0;
      rs_match = (uses_rs1 && ex_rd_q == id_rs1) || (uses_rs2 && ex_rd_q == id_rs2);
      stall    = ENABLE_HAZARD && !reset && id_valid && ex_q.mem_read && ex_rd_q != '0 && rs_match;
      kill_id  = flush || stall;
      ex_d     = hold ? ex_q : kill_id ? CTRL_BUBBLE : dec_ctrl;
      ex_rd_d  = hold ? ex_rd_q : kill_id ? '0 : dec_rd;
      mem_d    = hold ? mem_q : to_mem(ex_q);
      mem_rd_d = hold ? mem_rd_q : ex_rd_q;
      wb_d     = hold ? wb_q : to_wb(mem_q);
      wb_rd_d  = hold ? wb_rd_q : mem_rd_q;
      // Only an illegal opcode that would actually enter EX is recorded.
      ill_d    = ill_q || (id_valid && is_illegal && !hold && !kill_id);
      ill_op_d = (ill_d && !ill_q) ? id_opcode : ill_op_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q     <= CTRL_BUBBLE;
         ex_rd_q  <= '0;
         mem_q    <= MEM_BUBBLE;
         mem_rd_q <= '0;
         wb_q     <= WB_BUBBLE;
         wb_rd_q  <= '0;
         ill_q    <= 1'b0;
         ill_op_q <= '0;
      end else begin
         ex_q     <= ex_d;
         ex_rd_q  <= ex_rd_d;
         mem_q    <= mem_d;
         mem_rd_q <= mem_rd_d;
         wb_q     <= wb_d;
         wb_rd_q  <= wb_rd_d;
         ill_q    <= ill_d;
         ill_op_q <= ill_op_d;
      end
   end

   assign ex_alu_src     = ex_q.alu_src;
   assign ex_a_sel       = ex_q.a_sel;
   assign ex_alu_op      = ex_q.alu_op;
   assign ex_branch      = ex_q.branch;
   assign ex_jalr        = ex_q.jalr;
   assign ex_jal         = ex_q.jal;
   assign ex_rd          = ex_rd_q;
   assign mem_read       = mem_q.mem_read;
   assign mem_write      = mem_q.mem_write;
   assign mem_rd         = mem_rd_q;
   assign wb_reg_write   = wb_q.reg_write;
   assign wb_sel         = wb_q.wb_sel;
   assign wb_rd          = wb_rd_q;
   assign illegal        = ill_q;
   assign illegal_opcode = ill_op_q;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: scoreboard bench for pipe_ctrl_unit (default instance a, no-hazard/no-upper instance b)
module tb_pipe_ctrl_unit;
   localparam logic [6:0] R = 7'b0110011, LW = 7'b0000011, SW = 7'b0100011, BR = 7'b1100011;
   localparam logic [6:0] JAL = 7'b1101111, LUI = 7'b0110111, AUIPC = 7'b0010111, BAD = 7'b1111111;
   localparam int G_STALL = 0, G_EX = 1, G_MEM = 2, G_WB = 3, G_ILL = 4, G_ALL = 5;

   typedef struct {
      int          cyc;
      bit          inst;
      int          grp;
      logic [36:0] exp;
   } exp_t;

   logic clk = 1'b0, reset = 1'b1, id_valid = 1'b0, flush = 1'b0, hold = 1'b0;
   logic [6:0] id_opcode = '0;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   int cyc = 0, checks = 0, failures = 0;
   exp_t q[$];

   logic a_stall, a_alu_src, a_branch, a_jalr, a_jal, a_mr, a_mw, a_rw, a_ill;
   logic [1:0] a_a_sel, a_alu_op, a_wbs;
   logic [4:0] a_ex_rd, a_mem_rd, a_wb_rd;
   logic [6:0] a_ill_op;
   logic b_stall, b_alu_src, b_branch, b_jalr, b_jal, b_mr, b_mw, b_rw, b_ill;
   logic [1:0] b_a_sel, b_alu_op, b_wbs;
   logic [4:0] b_ex_rd, b_mem_rd, b_wb_rd;
   logic [6:0] b_ill_op;
   logic [36:0] va, vb;

   pipe_ctrl_unit dut_a (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush), .hold(hold),
      .stall(a_stall), .ex_alu_src(a_alu_src), .ex_a_sel(a_a_sel), .ex_alu_op(a_alu_op),
      .ex_branch(a_branch), .ex_jalr(a_jalr), .ex_jal(a_jal), .ex_rd(a_ex_rd),
      .mem_read(a_mr), .mem_write(a_mw), .mem_rd(a_mem_rd),
      .wb_reg_write(a_rw), .wb_sel(a_wbs), .wb_rd(a_wb_rd),
      .illegal(a_ill), .illegal_opcode(a_ill_op)
   );

   pipe_ctrl_unit #(.REG_ADDR_W(5), .ENABLE_UPPER(1'b0), .ENABLE_HAZARD(1'b0)) dut_b (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush), .hold(hold),
      .stall(b_stall), .ex_alu_src(b_alu_src), .ex_a_sel(b_a_sel), .ex_alu_op(b_alu_op),
      .ex_branch(b_branch), .ex_jalr(b_jalr), .ex_jal(b_jal), .ex_rd(b_ex_rd),
      .mem_read(b_mr), .mem_write(b_mw), .mem_rd(b_mem_rd),
      .wb_reg_write(b_rw), .wb_sel(b_wbs), .wb_rd(b_wb_rd),
      .illegal(b_ill), .illegal_opcode(b_ill_op)
   );

   assign va = {a_stall, a_alu_src, a_a_sel, a_alu_op, a_branch, a_jalr, a_jal, a_ex_rd,
                a_mr, a_mw, a_mem_rd, a_rw, a_wbs, a_wb_rd, a_ill, a_ill_op};
   assign vb = {b_stall, b_alu_src, b_a_sel, b_alu_op, b_branch, b_jalr, b_jal, b_ex_rd,
                b_mr, b_mw, b_mem_rd, b_rw, b_wbs, b_wb_rd, b_ill, b_ill_op};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [36:0] pick(input logic [36:0] v, input int grp);
      case (grp)
         G_STALL: return {36'd0, v[36]};
         G_EX:    return {24'd0, v[35:23]};
         G_MEM:   return {30'd0, v[22:16]};
         G_WB:    return {29'd0, v[15:8]};
         G_ILL:   return {29'd0, v[7:0]};
         default: return v;
      endcase
   endfunction

   function automatic logic [36:0] exv(input bit s, input logic [1:0] a, input logic [1:0] op,
                                       input bit b, input bit jr, input bit j, input logic [4:0] rd);
      return {24'd0, s, a, op, b, jr, j, rd};
   endfunction

   function automatic logic [36:0] memv(input bit r, input bit w, input logic [4:0] rd);
      return {30'd0, r, w, rd};
   endfunction

   function automatic logic [36:0] wbv(input bit rw, input logic [1:0] s, input logic [4:0] rd);
      return {29'd0, rw, s, rd};
   endfunction

   function automatic logic [36:0] illv(input bit i, input logic [6:0] op);
      return {29'd0, i, op};
   endfunction

   task automatic chk(input int at, input bit inst, input int grp, input logic [36:0] v);
      exp_t e;
      e.cyc  = at;
      e.inst = inst;
      e.grp  = grp;
      e.exp  = v;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input bit v, input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input bit fl = 1'b0, input bit hd = 1'b0, input bit rs = 1'b0);
      id_valid  = v;
      id_opcode = op;
      id_rs1    = r1;
      id_rs2    = r2;
      id_rd     = rd;
      flush     = fl;
      hold      = hd;
      reset     = rs;
   endtask

   // Monitor: every cycle, compare whatever expectations are due at this cycle.
   always @(negedge clk) begin
      logic [36:0] got;
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].cyc == cyc) begin
            got = pick(q[i].inst ? vb : va, q[i].grp);
            checks++;
            if (got !== q[i].exp) begin
               failures++;
               $display("FAIL cyc=%0d dut=%s grp=%0d got=%h want=%h", cyc, q[i].inst ? "b" : "a",
                        q[i].grp, got, q[i].exp);
            end
            q.delete(i);
         end
      end
   end

   initial begin
      logic [36:0] held;
      int n;
      // reset sampled at first edge; then LW x5 / ADD x6,x5,x7 load-use
      tick(); n = cyc;
      chk(n, 0, G_ALL, '0); chk(n, 1, G_ALL, '0);
      drv(1, LW, 5'd1, 5'd0, 5'd5);
      tick(); n = cyc;
      drv(1, R, 5'd5, 5'd7, 5'd6);
      chk(n, 0, G_STALL, 37'd1); chk(n, 1, G_STALL, '0);
      chk(n, 0, G_EX, exv(1, 2'b00, 2'b00, 0, 0, 0, 5'd5));
      tick(); n = cyc;
      chk(n, 0, G_STALL, '0); chk(n, 0, G_EX, '0); chk(n, 0, G_MEM, memv(1, 0, 5'd5));
      chk(n, 1, G_EX, exv(0, 2'b00, 2'b10, 0, 0, 0, 5'd6));
      tick(); n = cyc;
      drv(0, 7'd0, 5'd0, 5'd0, 5'd0);
      chk(n, 0, G_EX, exv(0, 2'b00, 2'b10, 0, 0, 0, 5'd6)); chk(n, 0, G_MEM, '0);
      chk(n, 0, G_WB, wbv(1, 2'b01, 5'd5)); chk(n, 1, G_WB, wbv(1, 2'b01, 5'd5));
      tick(); n = cyc;
      chk(n, 0, G_MEM, memv(0, 0, 5'd6)); chk(n, 0, G_WB, '0); chk(n, 1, G_WB, wbv(1, 2'b00, 5'd6));
      tick(); n = cyc;
      chk(n, 0, G_WB, wbv(1, 2'b00, 5'd6)); chk(n, 0, G_EX, '0);
      // LW x0 / ADD x1,x0,x0: no stall
      drv(1, LW, 5'd2, 5'd0, 5'd0);
      tick(); n = cyc;
      drv(1, R, 5'd0, 5'd0, 5'd1);
      chk(n, 0, G_STALL, '0); chk(n, 0, G_EX, exv(1, 2'b00, 2'b00, 0, 0, 0, 5'd0));
      // JAL x1 then SW (rd forced to 0)
      tick(); n = cyc;
      drv(1, JAL, 5'd5, 5'd0, 5'd1);
      chk(n, 0, G_STALL, '0); chk(n, 0, G_EX, exv(0, 2'b00, 2'b10, 0, 0, 0, 5'd1));
      tick(); n = cyc;
      drv(1, SW, 5'd2, 5'd3, 5'd9);
      chk(n, 0, G_EX, exv(0, 2'b00, 2'b00, 0, 0, 1, 5'd1));
      tick(); n = cyc;
      drv(0, 7'd0, 5'd0, 5'd0, 5'd0);
      chk(n, 0, G_EX, exv(1, 2'b00, 2'b00, 0, 0, 0, 5'd0)); chk(n, 0, G_MEM, memv(0, 0, 5'd1));
      tick(); n = cyc;
      chk(n, 0, G_WB, wbv(1, 2'b10, 5'd1)); chk(n, 0, G_MEM, memv(0, 1, 5'd0));
      tick(); n = cyc;
      chk(n, 0, G_WB, wbv(0, 2'b00, 5'd0));
      // LW x4, then BEQ x4 with flush and load-use together; then 3-cycle hold
      drv(1, LW, 5'd1, 5'd0, 5'd4);
      tick(); n = cyc;
      drv(1, BR, 5'd4, 5'd2, 5'd7, 1'b1);
      chk(n, 0, G_STALL, 37'd1);
      tick(); n = cyc;
      drv(1, BAD, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      held = {1'b0, 13'd0, 7'b1000100, 8'd0, 8'd0};
      chk(n, 0, G_ALL, held); chk(n, 1, G_ILL, '0);
      for (int k = 0; k < 3; k++) begin
         tick(); n = cyc;
         if (k == 2) drv(0, 7'd0, 5'd0, 5'd0, 5'd0);
         chk(n, 0, G_ALL, held); chk(n, 1, G_ILL, '0);
         checks++;
         if (va !== held) begin
            failures++;
            $display("FAIL hold k=%0d got=%h want=%h", k, va, held);
         end
      end
      tick(); n = cyc;
      chk(n, 0, G_WB, wbv(1, 2'b01, 5'd4)); chk(n, 0, G_EX, '0);
      // LUI legal on a, illegal on b; later illegal opcodes do not overwrite
      drv(1, LUI, 5'd0, 5'd0, 5'd3);
      tick(); n = cyc;
      drv(1, BAD, 5'd0, 5'd0, 5'd0);
      chk(n, 0, G_EX, exv(1, 2'b10, 2'b00, 0, 0, 0, 5'd3)); chk(n, 1, G_EX, '0);
      chk(n, 0, G_ILL, '0); chk(n, 1, G_ILL, illv(1, LUI));
      tick(); n = cyc;
      drv(1, AUIPC, 5'd0, 5'd0, 5'd8);
      chk(n, 0, G_ILL, illv(1, BAD)); chk(n, 1, G_ILL, illv(1, LUI));
      tick(); n = cyc;
      drv(1, SW, 5'd1, 5'd2, 5'd9);
      chk(n, 0, G_EX, exv(1, 2'b01, 2'b00, 0, 0, 0, 5'd8)); chk(n, 0, G_ILL, illv(1, BAD));
      chk(n, 1, G_ILL, illv(1, LUI));
      // SW, ADD, LW in WB/MEM/EX, then reset mid-stream with a load-use pair in ID
      tick();
      drv(1, R, 5'd1, 5'd2, 5'd6);
      tick();
      drv(1, LW, 5'd9, 5'd0, 5'd5);
      tick(); n = cyc;
      drv(1, R, 5'd5, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1);
      chk(n, 0, G_EX, exv(1, 2'b00, 2'b00, 0, 0, 0, 5'd5)); chk(n, 0, G_MEM, memv(0, 0, 5'd6));
      chk(n, 0, G_WB, wbv(0, 2'b00, 5'd0)); chk(n, 0, G_STALL, '0);
      tick(); n = cyc;
      drv(0, 7'd0, 5'd0, 5'd0, 5'd0);
      chk(n, 0, G_ALL, '0); chk(n, 1, G_ALL, '0);
      checks++;
      if (va !== '0 || vb !== '0) begin
         failures++;
         $display("FAIL reset va=%h vb=%h", va, vb);
      end
      tick(); n = cyc;
      chk(n, 0, G_ALL, '0); chk(n, 1, G_ALL, '0);
      repeat (3) tick();
      foreach (q[i]) begin
         checks++;
         failures++;
         $display("FAIL unchecked cyc=%0d dut=%0d grp=%0d got=none want=%h", q[i].cyc, q[i].inst, q[i].grp, q[i].exp);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
